// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the test-pattern sequencer.
// Pattern indices name the generators wired to gen_rgb slices.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } seq_state_e;

  localparam int CHECKERBOARD = 0;
  localparam int RADIENT      = 1;

  localparam int FRAME_CNT_W = 10;

  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_hold_counter.sv
// Counts end-of-frame ticks; done fires on the tick that
// completes HOLD_FRAMES frames, and the count restarts.
module frame_hold_counter
  import pattern_sequencer_pkg::*;
#(
  parameter int HOLD_FRAMES = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clear,
  output logic done
);

  localparam logic [FRAME_CNT_W-1:0] LAST =
    FRAME_CNT_W'(HOLD_FRAMES - 1);

  logic [FRAME_CNT_W-1:0] cnt;

  assign done = tick & ~clear & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || done) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Selects one of NUM_PATTERNS generators, switching only at frame
// boundaries with one blanked frame between patterns.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter  int NUM_PATTERNS = 4,
  parameter  int RGB_W        = 6,
  parameter  int HOLD_FRAMES  = 120,
  localparam int SEL_W        = sel_width(NUM_PATTERNS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      active,
  input  logic                      next_frame,
  input  logic [SEL_W-1:0]          req_pattern,
  input  logic                      req_valid,
  input  logic                      auto_mode,
  input  logic [NUM_PATTERNS*RGB_W-1:0] gen_rgb,
  output logic [NUM_PATTERNS-1:0]   gen_active,
  output logic [NUM_PATTERNS-1:0]   gen_next_frame,
  output logic [RGB_W-1:0]          rgb,
  output logic [SEL_W-1:0]          cur_pattern,
  output logic                      busy
);

  localparam logic [SEL_W:0] NUM_P =
    (SEL_W + 1)'(NUM_PATTERNS);
  localparam logic [SEL_W-1:0] LAST_P =
    SEL_W'(NUM_PATTERNS - 1);

  seq_state_e       state, state_n;
  logic [SEL_W-1:0] tgt, tgt_n, cur_n, nxt;
  logic             req_ok, hold_tick, hold_clr, hold_done;
  logic             shown;
  logic [RGB_W-1:0] sel_rgb;

  // x/y are routed to the generators outside this block
  logic unused_xy;
  assign unused_xy = ^{x, y};

  assign busy      = (state != SHOW);
  assign shown     = (state != BLANK);
  assign hold_tick = next_frame & auto_mode & (state == SHOW);
  assign hold_clr  = ~auto_mode | (state != SHOW);
  assign nxt       = (cur_pattern == LAST_P) ? '0
                                             : cur_pattern + 1'b1;
  assign req_ok    = req_valid & ~auto_mode
                   & ({1'b0, req_pattern} < NUM_P);

  frame_hold_counter #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (hold_tick),
    .clear(hold_clr),
    .done (hold_done)
  );

  always_comb begin
    state_n = state;
    cur_n   = cur_pattern;
    tgt_n   = tgt;
    unique case (state)
      SHOW: begin
        unique case (1'b1)
          hold_done: begin
            tgt_n   = nxt;
            cur_n   = nxt;
            state_n = BLANK;
          end
          req_ok && (req_pattern != cur_pattern): begin
            tgt_n   = req_pattern;
            state_n = PENDING;
          end
          default: ;
        endcase
      end
      PENDING: begin
        if (req_ok && (req_pattern == cur_pattern)) begin
          state_n = SHOW;
        end else begin
          if (req_ok) tgt_n = req_pattern;
          if (next_frame) begin
            cur_n   = req_ok ? req_pattern : tgt;
            state_n = BLANK;
          end
        end
      end
      BLANK: begin
        if (next_frame) state_n = SHOW;
      end
      default: state_n = SHOW;
    endcase
  end

  always_comb begin
    sel_rgb        = '0;
    gen_active     = '0;
    gen_next_frame = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (cur_pattern == SEL_W'(i)) begin
        sel_rgb           = gen_rgb[i*RGB_W +: RGB_W];
        gen_active[i]     = active & shown;
        gen_next_frame[i] = next_frame;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHOW;
      cur_pattern <= '0;
      tgt         <= '0;
      rgb         <= '0;
    end else begin
      state       <= state_n;
      cur_pattern <= cur_n;
      tgt         <= tgt_n;
      rgb         <= (active && shown) ? sel_rgb : '0;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: vector table,
// auto-cycling, reset-in-blank and out-of-range requests.
module tb_pattern_sequencer;

  localparam int NP = 4;
  localparam int W  = 6;
  localparam int HF = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [9:0]      x, y;
  logic            active, next_frame, auto_mode;
  logic [SW-1:0]   req_pattern;
  logic            req_valid;
  logic [NP*W-1:0] gen_rgb;
  logic [NP-1:0]   gen_active, gen_next_frame;
  logic [W-1:0]    rgb;
  logic [SW-1:0]   cur_pattern;
  logic            busy;

  logic [2:0]      req5;
  logic            rv5;
  logic [5*W-1:0]  gen_rgb5;
  logic [4:0]      gact5, gnf5;
  logic [W-1:0]    rgb5;
  logic [2:0]      cur5;
  logic            busy5;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] slice[NP];

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NUM_PATTERNS(NP), .RGB_W(W), .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .active(active), .next_frame(next_frame),
    .req_pattern(req_pattern), .req_valid(req_valid),
    .auto_mode(auto_mode), .gen_rgb(gen_rgb),
    .gen_active(gen_active), .gen_next_frame(gen_next_frame),
    .rgb(rgb), .cur_pattern(cur_pattern), .busy(busy)
  );

  pattern_sequencer #(
    .NUM_PATTERNS(5), .RGB_W(W), .HOLD_FRAMES(HF)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .active(active), .next_frame(next_frame),
    .req_pattern(req5), .req_valid(rv5),
    .auto_mode(auto_mode), .gen_rgb(gen_rgb5),
    .gen_active(gact5), .gen_next_frame(gnf5),
    .rgb(rgb5), .cur_pattern(cur5), .busy(busy5)
  );

  typedef struct {
    logic       act, nf, rv;
    logic [1:0] rp;
    logic [3:0] gact, gnf;
    logic       busy;
    logic [1:0] cur;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic a, logic n, logic v,
      logic [1:0] p, logic [3:0] ga, logic [3:0] gn,
      logic b, logic [1:0] c, logic [5:0] r);
    vec_t t;
    t.act = a; t.nf = n; t.rv = v; t.rp = p;
    t.gact = ga; t.gnf = gn; t.busy = b; t.cur = c; t.rgb = r;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_rgb(input string nm);
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 1, 0);
    end else begin
      chk(nm, rgb, exp_q.pop_front());
    end
  endtask

  task automatic pix(input logic a, input logic [5:0] e);
    active = a;
    exp_q.push_back(e);
    tick();
    pop_rgb("rgb_pix");
  endtask

  task automatic pulse_nf();
    active = 1'b0;
    next_frame = 1'b1;
    exp_q.push_back('0);
    tick();
    next_frame = 1'b0;
    pop_rgb("rgb_nf");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    slice[0] = 6'h2A; slice[1] = 6'h15;
    slice[2] = 6'h33; slice[3] = 6'h0C;
    rst_n = 1'b0; x = 10'd5; y = 10'd7;
    active = 1'b0; next_frame = 1'b0; auto_mode = 1'b0;
    req_pattern = '0; req_valid = 1'b0;
    gen_rgb = {slice[3], slice[2], slice[1], slice[0]};
    req5 = '0; rv5 = 1'b0;
    gen_rgb5 = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05};

    tbl[0]  = mk(1,0,0,0, 4'b0001,4'b0000, 0,0,6'h2A);
    tbl[1]  = mk(1,0,1,2, 4'b0001,4'b0000, 1,0,6'h2A);
    tbl[2]  = mk(1,0,0,0, 4'b0001,4'b0000, 1,0,6'h2A);
    tbl[3]  = mk(0,1,0,0, 4'b0000,4'b0001, 1,2,6'h00);
    tbl[4]  = mk(1,0,0,0, 4'b0000,4'b0000, 1,2,6'h00);
    tbl[5]  = mk(1,0,1,1, 4'b0000,4'b0000, 1,2,6'h00);
    tbl[6]  = mk(0,1,0,0, 4'b0000,4'b0100, 0,2,6'h00);
    tbl[7]  = mk(1,0,0,0, 4'b0100,4'b0000, 0,2,6'h33);
    tbl[8]  = mk(0,0,0,0, 4'b0000,4'b0000, 0,2,6'h00);
    tbl[9]  = mk(1,0,1,2, 4'b0100,4'b0000, 0,2,6'h33);
    tbl[10] = mk(1,0,1,0, 4'b0100,4'b0000, 1,2,6'h33);
    tbl[11] = mk(1,0,1,3, 4'b0100,4'b0000, 1,2,6'h33);
    tbl[12] = mk(0,1,1,1, 4'b0000,4'b0100, 1,1,6'h00);
    tbl[13] = mk(0,1,0,0, 4'b0000,4'b0010, 0,1,6'h00);
    tbl[14] = mk(1,0,0,0, 4'b0010,4'b0000, 0,1,6'h15);
    tbl[15] = mk(1,0,1,3, 4'b0010,4'b0000, 1,1,6'h15);
    tbl[16] = mk(1,0,1,1, 4'b0010,4'b0000, 0,1,6'h15);
    tbl[17] = mk(0,1,0,0, 4'b0000,4'b0010, 0,1,6'h00);
    tbl[18] = mk(1,0,0,0, 4'b0010,4'b0000, 0,1,6'h15);

    #12;
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_cur", cur_pattern, 0);
    chk("rst_rgb", rgb, 0);

    foreach (tbl[i]) begin
      active      = tbl[i].act;
      next_frame  = tbl[i].nf;
      req_valid   = tbl[i].rv;
      req_pattern = tbl[i].rp;
      #1;
      chk($sformatf("gact_%0d", i), gen_active, tbl[i].gact);
      chk($sformatf("gnf_%0d", i), gen_next_frame, tbl[i].gnf);
      exp_q.push_back(tbl[i].rgb);
      tick();
      chk($sformatf("busy_%0d", i), busy, tbl[i].busy);
      chk($sformatf("cur_%0d", i), cur_pattern, tbl[i].cur);
      pop_rgb($sformatf("rgb_%0d", i));
    end
    req_valid = 1'b0;
    next_frame = 1'b0;

    do_reset();
    auto_mode = 1'b1;
    for (int k = 0; k < NP; k++) begin
      int n;
      n = (k + 1) % NP;
      pulse_nf();
      chk("auto_hold_cur", cur_pattern, k);
      chk("auto_hold_busy", busy, 0);
      if (k == 0) begin
        req_valid = 1'b1; req_pattern = 2'd3;
        pix(1'b1, slice[0]);
        req_valid = 1'b0;
        chk("auto_req_ignored", busy, 0);
      end
      pulse_nf();
      chk("auto_sw_cur", cur_pattern, n);
      chk("auto_sw_busy", busy, 1);
      active = 1'b1;
      #1;
      chk("auto_blank_gact", gen_active, 0);
      pix(1'b1, '0);
      pulse_nf();
      chk("auto_show_busy", busy, 0);
      chk("auto_show_cur", cur_pattern, n);
      pix(1'b1, slice[n]);
    end

    pulse_nf();
    pulse_nf();
    chk("autofall_blank", busy, 1);
    auto_mode = 1'b0;
    pulse_nf();
    chk("autofall_cur", cur_pattern, 1);
    chk("autofall_busy", busy, 0);
    pix(1'b1, slice[1]);

    req_valid = 1'b1; req_pattern = 2'd3;
    pix(1'b1, slice[1]);
    req_valid = 1'b0;
    pulse_nf();
    chk("blank_cur", cur_pattern, 3);
    pix(1'b1, '0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_rgb", rgb, 0);
    chk("arst_cur", cur_pattern, 0);
    chk("arst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    tick();
    pix(1'b1, slice[0]);
    chk("arst_gact", gen_active, 4'b0001);

    for (int v = 5; v < 8; v++) begin
      rv5 = 1'b1; req5 = 3'(v);
      tick();
      chk($sformatf("oor_busy_%0d", v), busy5, 0);
    end
    req5 = 3'd4;
    tick();
    rv5 = 1'b0;
    chk("inr_busy", busy5, 1);
    chk("inr_cur", cur5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
